// File: rtl/pc_pkg.sv
// Shared encodings for the PC / branch unit: condition codes, flag positions,
// run/halt state and 2-bit branch counter values.
package pc_pkg;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_VS  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition check: condition code + {Z,V,N} flags -> taken.
module branch_cond_eval
  import pc_pkg::*;
(
  input  logic [2:0] ccc_i,
  input  logic [2:0] flags_i,
  output logic       taken_c
);

  logic z, v, n;

  always_comb begin : eval
    z       = flags_i[FLAG_Z];
    v       = flags_i[FLAG_V];
    n       = flags_i[FLAG_N];
    taken_c = 1'b0;
    case (ccc_i)
      CC_NE:   taken_c = !z;
      CC_EQ:   taken_c = z;
      CC_GT:   taken_c = !z && !n;
      CC_LT:   taken_c = n;
      CC_GE:   taken_c = z || (!z && !n);
      CC_LE:   taken_c = n || z;
      CC_VS:   taken_c = v;
      default: taken_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with branch resolution and run/halt control.
// Define PC_BHT_EN to add a direct-mapped BTB with 2-bit counters for next-fetch prediction.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int unsigned    PC_W      = 16,
  parameter int unsigned    IMM_W     = 9,
  parameter int unsigned    BTB_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              br_valid_i,
  input  logic [PC_W-1:0]   br_pc_i,
  input  logic [2:0]        ccc_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [2:0]        flags_i,
  input  logic              br_is_reg_i,
  input  logic [PC_W-1:0]   br_reg_i,
  input  logic              pred_taken_i,
  input  logic [PC_W-1:0]   pred_target_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc_plus2_o,
  output logic              pred_taken_o,
  output logic [PC_W-1:0]   pred_target_o,
  output logic              redirect_o,
  output logic              flush_o,
  output logic              halted_o
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_c;
  logic [PC_W-1:0] imm_sx, br_seq, br_target, correct_next, pred_next;
  logic            redirect_c;

  branch_cond_eval u_cond (
    .ccc_i   (ccc_i),
    .flags_i (flags_i),
    .taken_c (taken_c)
  );

  // Resolve the decode-stage branch and compare against what fetch assumed.
  always_comb begin : resolve
    imm_sx       = PC_W'($signed(imm_i));
    br_seq       = br_pc_i + PC_W'(2);
    br_target    = br_is_reg_i ? (br_reg_i & ~PC_W'(1)) : (br_seq + (imm_sx << 1));
    correct_next = taken_c ? br_target : br_seq;
    pred_next    = pred_taken_i ? pred_target_i : br_seq;
    redirect_c   = br_valid_i && (correct_next != pred_next);
  end

  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_q + PC_W'(2);

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // A redirect means any halt came from a wrong-path fetch, so it always resumes.
  always_comb begin : next_state
    state_d = state_q;
    if (redirect_c)                                  state_d = ST_RUN;
    else if (state_q == ST_RUN && halt_i && !stall_i) state_d = ST_HALT;
  end

  always_comb begin : state_outputs
    redirect_o = redirect_c;
    flush_o    = redirect_c;
    halted_o   = (state_q == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin : pc_reg
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Redirect outranks stall and halt; otherwise follow the fetch prediction.
  always_comb begin : next_pc
    pc_d = pc_q;
    if (redirect_c)                           pc_d = correct_next;
    else if (!stall_i && state_q == ST_RUN)   pc_d = pred_target_o;
  end

`ifdef PC_BHT_EN
  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = PC_W - IDX_W - 1;

  logic [BTB_DEPTH-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_d [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_q [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_d [BTB_DEPTH];
  logic [1:0]           ctr_q [BTB_DEPTH];
  logic [1:0]           ctr_d [BTB_DEPTH];
  logic [IDX_W-1:0]     lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 lk_hit, up_hit;

  always_comb begin : btb_lookup
    lk_idx        = pc_q[IDX_W:1];
    lk_tag        = pc_q[PC_W-1:IDX_W+1];
    lk_hit        = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_plus2_o;
  end

  // Train on every resolved branch, stalled or not; allocate only on taken.
  always_comb begin : btb_update
    vld_d  = vld_q;
    tag_d  = tag_q;
    tgt_d  = tgt_q;
    ctr_d  = ctr_q;
    up_idx = br_pc_i[IDX_W:1];
    up_tag = br_pc_i[PC_W-1:IDX_W+1];
    up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (br_valid_i) begin
      if (up_hit) begin
        if (taken_c) begin
          tgt_d[up_idx] = br_target;
          if (ctr_q[up_idx] != CTR_ST) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
        end else if (ctr_q[up_idx] != CTR_SNT) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (taken_c) begin
        vld_d[up_idx] = 1'b1;
        tag_d[up_idx] = up_tag;
        tgt_d[up_idx] = br_target;
        ctr_d[up_idx] = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : btb_regs
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(BTB_DEPTH); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
    end
  end
`else
  always_comb begin : static_pred
    pred_taken_o  = 1'b0;
    pred_target_o = pc_plus2_o;
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus random branch traffic
// compared against a behavioural next-PC / BTB model.
module tb_pc_branch_unit;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned IMM_W     = 9;
  localparam int unsigned BTB_DEPTH = 8;
  localparam int          PC_MOD    = 65536;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall_i, halt_i, br_valid_i, br_is_reg_i, pred_taken_i;
  logic [PC_W-1:0]   br_pc_i, br_reg_i, pred_target_i;
  logic [2:0]        ccc_i, flags_i;
  logic [IMM_W-1:0]  imm_i;
  logic [PC_W-1:0]   pc_o, pc_plus2_o, pred_target_o;
  logic              pred_taken_o, redirect_o, flush_o, halted_o;

  always #5 clk = ~clk;

  pc_branch_unit #(
    .PC_W(PC_W), .IMM_W(IMM_W), .BTB_DEPTH(BTB_DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .halt_i(halt_i),
    .br_valid_i(br_valid_i), .br_pc_i(br_pc_i), .ccc_i(ccc_i), .imm_i(imm_i),
    .flags_i(flags_i), .br_is_reg_i(br_is_reg_i), .br_reg_i(br_reg_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .pc_o(pc_o), .pc_plus2_o(pc_plus2_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .redirect_o(redirect_o), .flush_o(flush_o),
    .halted_o(halted_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: architectural PC, halt flag, BTB contents.
  int m_pc;
  bit m_halt;
  bit m_vld [BTB_DEPTH];
  int m_tag [BTB_DEPTH];
  int m_tgt [BTB_DEPTH];
  int m_ctr [BTB_DEPTH];

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int br_dest(input int pc, input bit is_reg, input int regv,
                                 input logic [IMM_W-1:0] imm);
    int off;
    off = int'($signed(imm)) * 2;
    if (is_reg) return (regv % PC_MOD) - ((regv % PC_MOD) % 2);
    return (((pc + 2 + off) % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic void m_predict(input int pc, output bit pt, output int ptgt);
    int idx, tg;
    idx = (pc / 2) % BTB_DEPTH;
    tg  = pc / (2 * BTB_DEPTH);
    pt  = 1'b0;
`ifdef PC_BHT_EN
    pt  = m_vld[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
`endif
    ptgt = pt ? m_tgt[idx] : (pc + 2) % PC_MOD;
  endfunction

  task automatic set_idle();
    stall_i = 1'b0; halt_i = 1'b0; br_valid_i = 1'b0; br_pc_i = '0; ccc_i = '0;
    imm_i = '0; flags_i = '0; br_is_reg_i = 1'b0; br_reg_i = '0;
    pred_taken_i = 1'b0; pred_target_i = '0;
  endtask

  task automatic set_branch(input int pc, input int ccc, input int flags, input bit is_reg,
                            input int regv, input int imm, input bit pt, input int ptgt);
    br_valid_i = 1'b1; br_pc_i = 16'(pc); ccc_i = 3'(ccc); flags_i = 3'(flags);
    br_is_reg_i = is_reg; br_reg_i = 16'(regv); imm_i = 9'(imm);
    pred_taken_i = pt; pred_target_i = 16'(ptgt);
  endtask

  // Called just after a falling edge with inputs applied; checks, clocks, advances model.
  task automatic cycle();
    bit taken, redir, pt, hit;
    int tgt, cn, pn, ptgt, idx, tg;
    #1;
    m_predict(m_pc, pt, ptgt);
    check_eq("pc", pc_o, m_pc);
    check_eq("pc_plus2", pc_plus2_o, (m_pc + 2) % PC_MOD);
    check_eq("halted", halted_o, m_halt);
    check_eq("pred_taken", pred_taken_o, pt);
    check_eq("pred_target", pred_target_o, ptgt);
    taken = cond_true(ccc_i, flags_i);
    tgt   = br_dest(int'(br_pc_i), br_is_reg_i, int'(br_reg_i), imm_i);
    cn    = taken ? tgt : (int'(br_pc_i) + 2) % PC_MOD;
    pn    = pred_taken_i ? int'(pred_target_i) : (int'(br_pc_i) + 2) % PC_MOD;
    redir = br_valid_i && (cn != pn);
    check_eq("redirect", redirect_o, redir);
    check_eq("flush", flush_o, redir);
    @(posedge clk);
    if (br_valid_i) begin
      idx = (int'(br_pc_i) / 2) % BTB_DEPTH;
      tg  = int'(br_pc_i) / (2 * BTB_DEPTH);
      hit = m_vld[idx] && (m_tag[idx] == tg);
      if (hit) begin
        if (taken) begin
          m_tgt[idx] = tgt;
          if (m_ctr[idx] < 3) m_ctr[idx]++;
        end else if (m_ctr[idx] > 0) m_ctr[idx]--;
      end else if (taken) begin
        m_vld[idx] = 1'b1; m_tag[idx] = tg; m_tgt[idx] = tgt; m_ctr[idx] = 2;
      end
    end
    if (redir) begin
      m_pc = cn; m_halt = 1'b0;
    end else if (!stall_i && !m_halt) begin
      m_pc = ptgt;
      if (halt_i) m_halt = 1'b1;
    end
    @(negedge clk);
  endtask

  int bp;

  initial begin
    set_idle();
    rst_n  = 1'b0;
    m_pc   = 0;
    m_halt = 1'b0;
    for (int i = 0; i < int'(BTB_DEPTH); i++) begin
      m_vld[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_pc", pc_o, 16'h0000);
    check_eq("rst_halted", halted_o, 1'b0);
    check_eq("rst_redirect", redirect_o, 1'b0);
    check_eq("rst_flush", flush_o, 1'b0);
    check_eq("rst_pred_taken", pred_taken_o, 1'b0);
    rst_n = 1'b1;

    // Sequential fetch 0,2,4,6.
    repeat (4) cycle();
    check_eq("seq_pc", pc_o, 16'h0008);

    // Conditional B, Z=1 taken backwards, predicted not-taken.
    set_branch(16'h0010, 1, 3'b100, 1'b0, 0, 9'h1FE, 1'b0, 0);
    #1 check_eq("beq_redirect", redirect_o, 1'b1);
    cycle();
    set_idle();
    #1 check_eq("beq_pc", pc_o, 16'h000E);

    // Same branch, Z=0: not taken, correctly predicted.
    set_branch(16'h0010, 1, 3'b000, 1'b0, 0, 9'h1FE, 1'b0, 0);
    #1 check_eq("bne_redirect", redirect_o, 1'b0);
    cycle();
    set_idle();
    check_eq("bne_pc", pc_o, 16'h0010);

    // Register branch under stall.
    set_branch(16'h0050, 7, 0, 1'b1, 16'h1235, 0, 1'b0, 0);
    stall_i = 1'b1;
    #1 check_eq("br_redirect", redirect_o, 1'b1);
    cycle();
    set_idle();
    stall_i = 1'b1;
    cycle();
    check_eq("br_stall_pc", pc_o, 16'h1234);

    // Wrap at top of address space.
    set_idle();
    set_branch(16'h0060, 7, 0, 1'b1, 16'hFFFC, 0, 1'b0, 0);
    cycle();
    set_idle();
    repeat (2) cycle();
    check_eq("wrap_pc", pc_o, 16'h0000);

    // Halt, hold through idle and a correctly predicted branch, then redirect out.
    set_branch(16'h0002, 7, 0, 1'b1, 16'h0020, 0, 1'b0, 0);
    cycle();
    set_idle();
    halt_i = 1'b1;
    cycle();
    set_idle();
    repeat (10) cycle();
    check_eq("halt_flag", halted_o, 1'b1);
    check_eq("halt_pc", pc_o, 16'h0022);
    set_branch(16'h0030, 7, 0, 1'b0, 0, 4, 1'b1, 16'h003A);
    cycle();
    check_eq("halt_no_redir", halted_o, 1'b1);
    set_branch(16'h0030, 7, 0, 1'b0, 0, 4, 1'b0, 0);
    cycle();
    set_idle();
    check_eq("resume_halted", halted_o, 1'b0);
    check_eq("resume_pc", pc_o, 16'h003A);

    // Train a taken branch at 0x0040 -> 0x0080, then re-fetch 0x0040.
    repeat (2) begin
      set_branch(16'h0040, 7, 0, 1'b0, 0, 31, 1'b0, 0);
      cycle();
    end
    set_branch(16'h0102, 7, 0, 1'b1, 16'h0040, 0, 1'b0, 0);
    cycle();
    set_idle();
    #1;
`ifdef PC_BHT_EN
    check_eq("btb_pred_taken", pred_taken_o, 1'b1);
    check_eq("btb_pred_target", pred_target_o, 16'h0080);
`else
    check_eq("btb_pred_taken", pred_taken_o, 1'b0);
    check_eq("btb_pred_target", pred_target_o, 16'h0042);
`endif
    cycle();
    repeat (2) begin
      set_branch(16'h0040, 0, 3'b100, 1'b0, 0, 31, 1'b1, 16'h0080);
      cycle();
    end
    set_branch(16'h0104, 7, 0, 1'b1, 16'h0040, 0, 1'b0, 0);
    cycle();
    set_idle();
    #1 check_eq("btb_untrained", pred_taken_o, 1'b0);
    cycle();

    // Random branch traffic with stalls and halts.
    for (int i = 0; i < 500; i++) begin
      set_idle();
      stall_i = ($urandom_range(0, 7) == 0);
      halt_i  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bp = ($urandom_range(0, 1) == 1 ? 32'h0100 : 32'h0200) + 2 * $urandom_range(0, 15);
        br_valid_i   = 1'b1;
        br_pc_i      = 16'(bp);
        ccc_i        = 3'($urandom);
        flags_i      = 3'($urandom);
        br_is_reg_i  = ($urandom_range(0, 3) == 0);
        br_reg_i     = 16'($urandom);
        imm_i        = 9'($urandom);
        pred_taken_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1)
          pred_target_i = 16'(br_dest(bp, br_is_reg_i, int'(br_reg_i), imm_i));
        else
          pred_target_i = 16'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
